// File: rtl/sdq_fifo_ctrl.sv
// sdq_fifo_ctrl
//
// Valid/ready FIFO controller in front of the sdq_17x64 single-port SRAM
// macro. Entries pushed by the producer are written into the SRAM; a read
// engine fetches them back in order and stages the returned data into a
// 2-entry output buffer that feeds the consumer. The single SRAM port is
// shared: a read always wins over a write, so a write is only accepted in
// cycles where no read is being issued.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds push_valid/push_data
// until accepted; pop_valid/pop_data stay stable until popped.
//
// Ports:
//   clk, reset            sole clock; synchronous active-high reset
//   push_valid/ready/data producer side
//   pop_valid/ready/data  consumer side (pop_data is the output buffer head)
//   count                 total occupancy: SRAM + in-flight read + buffer
//   mem_addr/we/wd/ce     to the macro's addr_in/we_in/wd_in/ce_in
//   mem_rd                macro rd_out; valid the cycle after a read issue

module sdq_fifo_ctrl #(
    parameter int BITS       = 16,
    parameter int WORD_DEPTH = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = $clog2(WORD_DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [BITS-1:0]       push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [BITS-1:0]       pop_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [BITS-1:0]       mem_wd,
    output logic                  mem_ce,
    input  logic [BITS-1:0]       mem_rd
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(WORD_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(WORD_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  mem_cnt_q, mem_cnt_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [BITS-1:0]       ob_q [2];
    logic [BITS-1:0]       ob_d [2];
    logic [1:0]            ob_cnt_q, ob_cnt_d;

    logic       rd_issue;
    logic       read_fire;
    logic       push_fire;
    logic       pop_fire;
    logic [1:0] ob_cnt_after_pop;

    // A read is only launched when its data is guaranteed a slot in the
    // output buffer on return, counting any read already in flight. It
    // looks at registered state only, so it never depends on the consumer.
    assign rd_issue  = (mem_cnt_q != '0) &&
                       (({1'b0, ob_cnt_q} + {2'b00, rd_inflight_q}) < 3'd2);
    assign read_fire = rd_issue && !reset;

    assign push_ready = !reset && !rd_issue && (mem_cnt_q < DEPTH_CNT);
    assign push_fire  = push_valid && push_ready;

    assign pop_valid = (ob_cnt_q != 2'd0);
    assign pop_data  = ob_q[0];
    assign pop_fire  = pop_valid && pop_ready;

    assign count = mem_cnt_q + CNT_WIDTH'(rd_inflight_q) + CNT_WIDTH'(ob_cnt_q);

    // SRAM port drive: read, write, or idle (idle parks the address on rd_ptr).
    always_comb begin
        mem_ce   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = rd_ptr_q;
        mem_wd   = push_data;
        if (read_fire) begin
            mem_ce   = 1'b1;
            mem_addr = rd_ptr_q;
        end else if (push_fire) begin
            mem_ce   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = wr_ptr_q;
        end
    end

    // Pointers, SRAM occupancy and read-in-flight tracking.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mem_cnt_d     = mem_cnt_q;
        rd_inflight_d = read_fire;
        if (push_fire) begin
            wr_ptr_d  = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
            mem_cnt_d = mem_cnt_q + CNT_WIDTH'(1);
        end
        if (read_fire) begin
            rd_ptr_d  = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
            mem_cnt_d = mem_cnt_q - CNT_WIDTH'(1);
        end
    end

    // Output buffer: the pop shift happens first, then returning SRAM data
    // lands in the first free slot, so a simultaneous pop and append keeps
    // FIFO order. Overflow is impossible because reads are only issued when
    // a slot is reserved for them.
    always_comb begin
        ob_d[0]          = ob_q[0];
        ob_d[1]          = ob_q[1];
        ob_cnt_after_pop = ob_cnt_q - {1'b0, pop_fire};
        if (pop_fire) begin
            ob_d[0] = ob_q[1];
        end
        if (rd_inflight_q) begin
            if (ob_cnt_after_pop == 2'd0) begin
                ob_d[0] = mem_rd;
            end else begin
                ob_d[1] = mem_rd;
            end
        end
        ob_cnt_d = ob_cnt_after_pop + {1'b0, rd_inflight_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            ob_q[0]       <= '0;
            ob_q[1]       <= '0;
            ob_cnt_q      <= 2'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_cnt_q     <= mem_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            ob_q[0]       <= ob_d[0];
            ob_q[1]       <= ob_d[1];
            ob_cnt_q      <= ob_cnt_d;
        end
    end

endmodule

// File: tb/tb_sdq_fifo_ctrl.sv
// Testbench for sdq_fifo_ctrl with a behavioural model of the single-port
// SRAM macro (registered read data, write-through not modelled).
module tb_sdq_fifo_ctrl;

  localparam int BITS = 16;
  localparam int WORD_DEPTH = 2;
  localparam int ADDR_WIDTH = 5;
  localparam int CNT_WIDTH = $clog2(WORD_DEPTH + 3);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  push_valid;
  logic                  push_ready;
  logic [BITS-1:0]       push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [BITS-1:0]       pop_data;
  logic [CNT_WIDTH-1:0]  count;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [BITS-1:0]       mem_wd;
  logic                  mem_ce;
  logic [BITS-1:0]       mem_rd;

  sdq_fifo_ctrl #(
    .BITS(BITS), .WORD_DEPTH(WORD_DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_ce(mem_ce),
    .mem_rd(mem_rd)
  );

  // SRAM macro model
  logic [BITS-1:0] sram [32];
  always_ff @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_addr] <= mem_wd;
      else        mem_rd <= sram[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [BITS-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       pv;
    logic [15:0] pd;
    logic       pr;
    logic       e_prdy;
    logic       e_pval;
    logic [15:0] e_pdata;
    logic [2:0] e_cnt;
    logic       e_ce;
    logic       e_we;
    logic [4:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic pv, input logic [15:0] pd, input logic pr,
                         input logic e_prdy, input logic e_pval, input logic [15:0] e_pdata,
                         input logic [2:0] e_cnt, input logic e_ce, input logic e_we,
                         input logic [4:0] e_addr);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pd = pd; v.pr = pr;
    v.e_prdy = e_prdy; v.e_pval = e_pval; v.e_pdata = e_pdata; v.e_cnt = e_cnt;
    v.e_ce = e_ce; v.e_we = e_we; v.e_addr = e_addr;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [15:0] d);
    bit accepted = 0;
    push_valid = 1'b1;
    push_data = d;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      accepted = push_ready;
      next_cycle();
    end
    push_valid = 1'b0;
    chk("push_accepted", {31'd0, accepted}, 32'd1);
  endtask

  initial begin
    int first_pop, last_pop, pop_cnt, push_cnt, wr_idx, rd_idx;
    logic [15:0] next_d;
    logic [15:0] exp_head;
    bit got;

    reset = 1'b1; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    next_cycle();

    //       rst pv pd       pr | prdy pval pdata    cnt ce we addr
    add_vec(1, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 0, 0, 0);
    add_vec(0, 1, 16'hA001, 1,   1, 0, 16'h0000, 0, 1, 1, 0);
    add_vec(0, 0, 16'h0000, 1,   0, 0, 16'h0000, 1, 1, 0, 0);
    add_vec(0, 0, 16'h0000, 1,   1, 0, 16'h0000, 1, 0, 0, 1);
    add_vec(0, 0, 16'h0000, 1,   1, 1, 16'hA001, 1, 0, 0, 1);
    add_vec(0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0, 0, 1);
    // reset with push_valid high, then fill with pop_ready low
    add_vec(1, 1, 16'h0001, 0,   0, 0, 16'h0000, 0, 0, 0, 1);
    add_vec(0, 1, 16'h0001, 0,   1, 0, 16'h0000, 0, 1, 1, 0);
    add_vec(0, 1, 16'h0002, 0,   0, 0, 16'h0000, 1, 1, 0, 0);
    add_vec(0, 1, 16'h0002, 0,   1, 0, 16'h0000, 1, 1, 1, 1);
    add_vec(0, 1, 16'h0003, 0,   0, 1, 16'h0001, 2, 1, 0, 1);
    add_vec(0, 1, 16'h0003, 0,   1, 1, 16'h0001, 2, 1, 1, 0);
    add_vec(0, 1, 16'h0004, 0,   1, 1, 16'h0001, 3, 1, 1, 1);
    // full, output stalled for 5 cycles
    for (int i = 0; i < 5; i++)
      add_vec(0, 1, 16'h0005, 0, 0, 1, 16'h0001, 4, 0, 0, 0);
    // drain
    add_vec(0, 0, 16'h0000, 1,   0, 1, 16'h0001, 4, 0, 0, 0);
    add_vec(0, 0, 16'h0000, 1,   0, 1, 16'h0002, 3, 1, 0, 0);
    add_vec(0, 0, 16'h0000, 1,   0, 0, 16'h0000, 2, 1, 0, 1);
    add_vec(0, 0, 16'h0000, 1,   1, 1, 16'h0003, 2, 0, 0, 0);
    add_vec(0, 0, 16'h0000, 1,   1, 1, 16'h0004, 1, 0, 0, 0);
    add_vec(0, 0, 16'h0000, 0,   1, 0, 16'h0000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; push_valid = vecs[i].pv; push_data = vecs[i].pd; pop_ready = vecs[i].pr;
      @(negedge clk);
      chk($sformatf("v%0d_push_ready", i), {31'd0, push_ready}, {31'd0, vecs[i].e_prdy});
      chk($sformatf("v%0d_pop_valid", i), {31'd0, pop_valid}, {31'd0, vecs[i].e_pval});
      if (vecs[i].e_pval)
        chk($sformatf("v%0d_pop_data", i), {16'd0, pop_data}, {16'd0, vecs[i].e_pdata});
      chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d_mem_ce", i), {31'd0, mem_ce}, {31'd0, vecs[i].e_ce});
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_mem_addr", i), {27'd0, mem_addr}, {27'd0, vecs[i].e_addr});
      if (vecs[i].e_we)
        chk($sformatf("v%0d_mem_wd", i), {16'd0, mem_wd}, {16'd0, vecs[i].pd});
      next_cycle();
    end

    // ---------- streaming with wrap: push and pop continuously ----------
    reset_dut();
    next_d = 16'h1000; push_cnt = 0; pop_cnt = 0; wr_idx = 0; rd_idx = 0;
    first_pop = -1; last_pop = -1;
    pop_ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      push_valid = (push_cnt < 30);
      push_data = next_d;
      @(negedge clk);
      chk("we_is_handshake", {31'd0, mem_we}, {31'd0, push_valid && push_ready});
      if (mem_ce) chk("addr_in_range", {31'd0, mem_addr < 5'(WORD_DEPTH)}, 32'd1);
      if (mem_ce && mem_we) begin
        chk("wr_addr", {27'd0, mem_addr}, wr_idx % WORD_DEPTH);
        wr_idx++;
      end
      if (mem_ce && !mem_we) begin
        chk("rd_addr", {27'd0, mem_addr}, rd_idx % WORD_DEPTH);
        rd_idx++;
      end
      if (push_valid && push_ready) begin
        exp_q.push_back(next_d);
        next_d++;
        push_cnt++;
      end
      if (pop_valid && pop_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", {16'd0, pop_data}, 32'hFFFFFFFF);
        end else begin
          exp_head = exp_q.pop_front();
          chk("stream_pop_data", {16'd0, pop_data}, {16'd0, exp_head});
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pop_cnt++;
      end
      next_cycle();
    end
    push_valid = 1'b0;
    chk("stream_pop_count", pop_cnt, 30);
    chk("stream_leftover", exp_q.size(), 0);
    chk("stream_throughput", {31'd0, (last_pop - first_pop) <= 60}, 32'd1);
    @(negedge clk);
    chk("stream_count_end", {29'd0, count}, 0);
    next_cycle();
    exp_q.delete();

    // ---------- reset mid-stream with a read in flight ----------
    reset_dut();
    pop_ready = 1'b0;
    push_one(16'h0011);
    push_one(16'h0022);
    push_one(16'h0033);
    push_one(16'h0044);
    @(negedge clk);
    chk("mid_count_full", {29'd0, count}, 4);
    next_cycle();
    pop_ready = 1'b1;                 // pop head, leaves ob=1 mem=2
    @(negedge clk);
    chk("mid_pop_head", {16'd0, pop_data}, 16'h0011);
    next_cycle();
    pop_ready = 1'b0;                 // read issued this cycle
    @(negedge clk);
    chk("mid_read_ce", {31'd0, mem_ce}, 32'd1);
    chk("mid_read_we", {31'd0, mem_we}, 32'd0);
    next_cycle();
    reset = 1'b1;                     // read in flight, count 3
    @(negedge clk);
    chk("mid_count3", {29'd0, count}, 3);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_count", {29'd0, count}, 0);
    chk("post_rst_pop_valid", {31'd0, pop_valid}, 0);
    chk("post_rst_mem_ce", {31'd0, mem_ce}, 0);
    chk("post_rst_pop_data", {16'd0, pop_data}, 0);
    next_cycle();
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", {31'd0, pop_valid}, 0);
      next_cycle();
    end
    push_one(16'h5A5A);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (pop_valid) begin
        got = 1;
        chk("post_rst_data", {16'd0, pop_data}, 16'h5A5A);
      end
      next_cycle();
    end
    chk("post_rst_pop_seen", {31'd0, got}, 1);
    @(negedge clk);
    chk("final_count", {29'd0, count}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
